// File: rtl/data_sync_rx.sv
// Destination-side receiver for a 4-phase REQ/ACK multi-bit clock-domain crossing.
// Optional even-parity check on the captured bus is enabled by defining DATA_SYNC_RX_PARITY_EN.
module data_sync_rx #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_REQ,
`ifdef DATA_SYNC_RX_PARITY_EN
    input  logic                 UNSYNC_PAR,
    output logic                 PAR_ERR,
`endif
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 BUS_ACK,
    output logic [7:0]           XFER_CNT
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    logic [NUM_STAGES-1:0] r_syncChain;
    logic                  r_reqD;
    logic                  w_reqS;
    logic                  w_rise;

    state_t                r_state;
    state_t                w_nextState;
    logic                  w_capture;

    logic [BUS_WIDTH-1:0]  r_syncBus;
    logic                  r_enablePulse;
    logic                  r_busAck;
    logic [7:0]            r_xferCnt;

    // Only the request level crosses through the flop chain; the bus is sampled
    // once the registered handshake says it is stable.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_syncChain <= '0;
            r_reqD      <= 1'b0;
        end else begin
            r_syncChain <= {r_syncChain[NUM_STAGES-2:0], BUS_REQ};
            r_reqD      <= w_reqS;
        end
    end

    assign w_reqS = r_syncChain[NUM_STAGES-1];
    assign w_rise = w_reqS & ~r_reqD;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= IDLE;
            r_busAck <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_busAck <= (w_nextState == ACKED);
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_capture   = 1'b1;
                    w_nextState = ACKED;
                end
            end
            ACKED: begin
                if (!w_reqS) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_syncBus     <= '0;
            r_enablePulse <= 1'b0;
            r_xferCnt     <= 8'd0;
        end else begin
            r_enablePulse <= w_capture;
            if (w_capture) begin
                r_syncBus <= UNSYNC_BUS;
                r_xferCnt <= r_xferCnt + 8'd1;
            end
        end
    end

`ifdef DATA_SYNC_RX_PARITY_EN
    logic r_parErr;

    // A parity error still loads the bus and counts; it is only flagged.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_parErr <= 1'b0;
        end else if (w_capture) begin
            r_parErr <= (^UNSYNC_BUS) ^ UNSYNC_PAR;
        end
    end

    assign PAR_ERR = r_parErr;
`endif

    assign SYNC_BUS     = r_syncBus;
    assign ENABLE_PULSE = r_enablePulse;
    assign BUS_ACK      = r_busAck;
    assign XFER_CNT     = r_xferCnt;

endmodule
